// File: rtl/matmul_pkg.sv
// Shared types and width helpers for the streaming matrix multiplier.
package matmul_pkg;

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_OUTPUT  = 2'd2
  } state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

  // Accumulator holds N full-scale products without overflow.
  function automatic int acc_width(input int n, input int dw);
    return 2 * dw + clog2(n);
  endfunction

  function automatic int out_bytes(input int n, input int dw);
    return (acc_width(n, dw) + 7) / 8;
  endfunction

endpackage

// File: rtl/matmul_mac.sv
// Single multiply-accumulate lane; restarts the sum when clr is high.
// MATMUL_SIGNED_EN selects two's-complement operands; otherwise unsigned.
import matmul_pkg::*;

module matmul_mac #(
  parameter int DW    = 8,
  parameter int ACC_W = acc_width(3, 8)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [DW-1:0]    a,
  input  logic [DW-1:0]    b,
  output logic [ACC_W-1:0] acc
);

  logic [2*DW-1:0]  prod;
  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0] acc_d;
  logic [ACC_W-1:0] acc_q;

  always_comb begin
`ifdef MATMUL_SIGNED_EN
    prod     = (2*DW)'($signed(a)) * (2*DW)'($signed(b));
    prod_ext = ACC_W'($signed(prod));
`else
    prod     = (2*DW)'(a) * (2*DW)'(b);
    prod_ext = ACC_W'(prod);
`endif
    acc_d = (clr ? '0 : acc_q) + prod_ext;
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  acc_q <= '0;
    else if (en) acc_q <= acc_d;
  end

  assign acc = acc_q;

endmodule

// File: rtl/matmul_stream_core.sv
// N x N integer matrix multiplier: byte-serial load, single-MAC compute, byte-serial result.
// Define MATMUL_SIGNED_EN for two's-complement elements and sign-extended result bytes.
import matmul_pkg::*;

module matmul_stream_core #(
  parameter int N  = 3,
  parameter int DW = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       abort,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  input  logic       out_ready,
  output logic       busy,
  output logic       done
);

  localparam int ACC_W = acc_width(N, DW);
  localparam int OB    = out_bytes(N, DW);
  localparam int NN    = N * N;
  localparam int IW    = clog2(N);
  localparam int RW    = clog2(NN);
  localparam int LW    = clog2(2 * NN);
  localparam int BW    = clog2(OB);

  state_e          state_q, state_d;
  logic [LW-1:0]   ld_q, ld_d;
  logic [IW-1:0]   i_q, i_d, j_q, j_d, k_q, k_d;
  logic            drain_q, drain_d;
  logic            cw_q, cw_d;
  logic [RW-1:0]   cw_idx_q, cw_idx_d;
  logic [RW-1:0]   res_q, res_d;
  logic [BW-1:0]   byte_q, byte_d;

  logic [DW-1:0]    a_mem [NN];
  logic [DW-1:0]    b_mem [NN];
  logic [ACC_W-1:0] c_mem [NN];

  logic             in_accept;
  logic             mac_en;
  logic [RW-1:0]    a_idx, b_idx;
  logic [ACC_W-1:0] mac_acc;
  logic [ACC_W-1:0] c_sel;
  logic [8*OB-1:0]  c_ext;
  logic             k_last, j_last, i_last;

  assign in_ready  = (state_q == ST_LOAD);
  assign out_valid = (state_q == ST_OUTPUT);
  assign busy      = (state_q == ST_COMPUTE) || (state_q == ST_OUTPUT);

  assign in_accept = in_ready && in_valid && !abort;
  // The extra drain cycle lets the final sum land in c_mem before OUTPUT reads it.
  assign mac_en    = (state_q == ST_COMPUTE) && !drain_q && !abort;

  assign k_last = (k_q == IW'(N - 1));
  assign j_last = (j_q == IW'(N - 1));
  assign i_last = (i_q == IW'(N - 1));
  assign a_idx  = RW'(int'(i_q) * N + int'(k_q));
  assign b_idx  = RW'(int'(k_q) * N + int'(j_q));

  matmul_mac #(
    .DW    (DW),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (mac_en),
    .clr   (k_q == '0),
    .a     (a_mem[a_idx]),
    .b     (b_mem[b_idx]),
    .acc   (mac_acc)
  );

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_d  = state_q;
    ld_d     = ld_q;
    i_d      = i_q;
    j_d      = j_q;
    k_d      = k_q;
    drain_d  = drain_q;
    cw_d     = 1'b0;
    cw_idx_d = cw_idx_q;
    res_d    = res_q;
    byte_d   = byte_q;
    done     = 1'b0;

    if (abort) begin
      state_d = ST_LOAD;
      ld_d    = '0;
      i_d     = '0;
      j_d     = '0;
      k_d     = '0;
      drain_d = 1'b0;
      res_d   = '0;
      byte_d  = '0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (in_valid) begin
            if (ld_q == LW'(2 * NN - 1)) begin
              ld_d    = '0;
              state_d = ST_COMPUTE;
            end else begin
              ld_d = ld_q + LW'(1);
            end
          end
        end
        ST_COMPUTE: begin
          if (drain_q) begin
            drain_d = 1'b0;
            state_d = ST_OUTPUT;
          end else begin
            cw_d     = k_last;
            cw_idx_d = RW'(int'(i_q) * N + int'(j_q));
            if (!k_last) begin
              k_d = k_q + IW'(1);
            end else begin
              k_d = '0;
              if (!j_last) begin
                j_d = j_q + IW'(1);
              end else begin
                j_d = '0;
                if (!i_last) begin
                  i_d = i_q + IW'(1);
                end else begin
                  i_d     = '0;
                  drain_d = 1'b1;
                end
              end
            end
          end
        end
        ST_OUTPUT: begin
          if (out_ready) begin
            if (byte_q != BW'(OB - 1)) begin
              byte_d = byte_q + BW'(1);
            end else begin
              byte_d = '0;
              if (res_q != RW'(NN - 1)) begin
                res_d = res_q + RW'(1);
              end else begin
                res_d   = '0;
                state_d = ST_LOAD;
                done    = 1'b1;
              end
            end
          end
        end
        default: state_d = ST_LOAD;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_LOAD;
      ld_q     <= '0;
      i_q      <= '0;
      j_q      <= '0;
      k_q      <= '0;
      drain_q  <= 1'b0;
      cw_q     <= 1'b0;
      cw_idx_q <= '0;
      res_q    <= '0;
      byte_q   <= '0;
    end else begin
      state_q  <= state_d;
      ld_q     <= ld_d;
      i_q      <= i_d;
      j_q      <= j_d;
      k_q      <= k_d;
      drain_q  <= drain_d;
      cw_q     <= cw_d;
      cw_idx_q <= cw_idx_d;
      res_q    <= res_d;
      byte_q   <= byte_d;
    end
  end

  // NOTE: the operand and result arrays carry no reset; every entry is rewritten before it is read.
  always_ff @(posedge clk) begin
    if (in_accept) begin
      if (ld_q < LW'(NN)) a_mem[RW'(ld_q)]            <= in_data[DW-1:0];
      else                b_mem[RW'(ld_q - LW'(NN))] <= in_data[DW-1:0];
    end
    if (cw_q) c_mem[cw_idx_q] <= mac_acc;
  end

  always_comb begin
    c_sel = c_mem[res_q];
`ifdef MATMUL_SIGNED_EN
    c_ext = (8*OB)'($signed(c_sel));
`else
    c_ext = (8*OB)'(c_sel);
`endif
  end

  assign out_data = out_valid ? 8'(c_ext >> {byte_q, 3'b000}) : 8'h00;

endmodule

// File: tb/tb_matmul_stream_core.sv
// Self-checking bench for matmul_stream_core against a plain-arithmetic matrix product model.
`timescale 1ns/1ps
module tb_matmul_stream_core;

  localparam int N     = 3;
  localparam int DW    = 8;
  localparam int NN    = N * N;
  localparam int ACC_W = 2 * DW + $clog2(N);
  localparam int OB    = (ACC_W + 7) / 8;

  logic       clk       = 1'b0;
  logic       rst_n     = 1'b0;
  logic       abort     = 1'b0;
  logic       in_valid  = 1'b0;
  logic [7:0] in_data   = 8'h00;
  logic       out_ready = 1'b0;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;
  int ma [NN];
  int mb [NN];
  logic [7:0] exp_q [$];
  logic [7:0] got_q [$];

  matmul_stream_core #(.N(N), .DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .abort     (abort),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic longint elem(input int raw);
    longint v;
    v = longint'(raw & ((1 << DW) - 1));
`ifdef MATMUL_SIGNED_EN
    if (v >= (longint'(1) << (DW - 1))) v = v - (longint'(1) << DW);
`endif
    return v;
  endfunction

  // C = A x B, each entry emitted as OB little-endian bytes of its two's-complement value.
  function automatic void build_expected();
    longint s;
    exp_q.delete();
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        s = 0;
        for (int k = 0; k < N; k++) s = s + elem(ma[i*N+k]) * elem(mb[k*N+j]);
        for (int b = 0; b < OB; b++) exp_q.push_back(8'(s >>> (8 * b)));
      end
    end
  endfunction

  function automatic void fill_const(input int av, input int bv);
    for (int e = 0; e < NN; e++) begin
      ma[e] = av;
      mb[e] = bv;
    end
  endfunction

  function automatic void fill_random();
    for (int e = 0; e < NN; e++) begin
      ma[e] = int'($urandom_range(255));
      mb[e] = int'($urandom_range(255));
    end
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, in_ready, 1'b1);
    check({tag, "_out_valid"}, out_valid, 1'b0);
    check({tag, "_out_data"}, out_data, 8'h00);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
  endtask

  // Returns 1 ns after the edge that accepts the last element.
  task automatic load_all(input int gap_pct);
    int e;
    int guard;
    e = 0;
    guard = 0;
    while (e < 2 * NN && guard < 5000) begin
      guard++;
      @(negedge clk);
      in_valid = ($urandom_range(99) >= gap_pct);
      if (e < NN) in_data = 8'(ma[e]);
      else        in_data = 8'(mb[e-NN]);
      #1;
      if (in_valid && in_ready) e++;
    end
    check("load_count", e, 2 * NN);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_output(input bit check_lat);
    int lat;
    lat = 0;
    check("compute_flags", {busy, in_ready, out_valid}, 3'b100);
    while (!out_valid && lat < 1000) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (check_lat) check("latency", lat, N * N * N + 1);
    else           check("output_reached", out_valid, 1'b1);
  endtask

  task automatic receive(input int rdy_pct, input int stall_at, input bit abort_last);
    int idx;
    int guard;
    int dones;
    bit stalled;
    idx = 0;
    guard = 0;
    dones = 0;
    stalled = 0;
    got_q.delete();
    while (idx < exp_q.size() && guard < 5000) begin
      guard++;
      @(negedge clk);
      if (abort_last && idx == exp_q.size() - 1) begin
        out_ready = 1'b1;
        abort = 1'b1;
        #1;
        check("abort_last_valid", out_valid, 1'b1);
        check("abort_last_done", done, 1'b0);
        @(posedge clk);
        #1;
        abort = 1'b0;
        out_ready = 1'b0;
        check("abort_last_state", {out_valid, busy, in_ready}, 3'b001);
        break;
      end
      if (idx == stall_at && !stalled) begin
        stalled = 1;
        out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          #1;
          check("stall_data", out_data, exp_q[idx]);
          check("stall_valid", out_valid, 1'b1);
          @(negedge clk);
        end
      end
      out_ready = ($urandom_range(99) < rdy_pct);
      #1;
      if (done) dones++;
      if (out_valid && out_ready) begin
        check("rx_byte", out_data, exp_q[idx]);
        check("rx_done", done, (idx == exp_q.size() - 1));
        got_q.push_back(out_data);
        idx++;
      end
    end
    if (!abort_last) begin
      check("rx_count", idx, exp_q.size());
      check("done_count", dones, 1);
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("rx_end_state", {out_valid, busy, in_ready}, 3'b001);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    #1;
    check_reset_outputs("por");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Identity times 1..9.
    for (int e = 0; e < NN; e++) begin
      ma[e] = (e / N == e % N) ? 1 : 0;
      mb[e] = e + 1;
    end
    build_expected();
    load_all(0);
    wait_output(1);
    receive(100, -1, 0);
    check("ident_b0", got_q[0], 8'h01);
    check("ident_b1", got_q[1], 8'h00);
    check("ident_b2", got_q[2], 8'h00);
    check("ident_last", got_q[NN*OB-OB], 8'h09);

    // Full-scale operands.
`ifdef MATMUL_SIGNED_EN
    fill_const(8'h80, 8'h80);
    build_expected();
    load_all(0);
    wait_output(1);
    receive(100, -1, 0);
    check("min_min_b0", got_q[0], 8'h00);
    check("min_min_b1", got_q[1], 8'hC0);
    check("min_min_b2", got_q[2], 8'h00);
    fill_const(8'h80, 8'h7F);
    build_expected();
    load_all(0);
    wait_output(1);
    receive(100, -1, 0);
    check("min_max_b0", got_q[0], 8'h80);
    check("min_max_b1", got_q[1], 8'h41);
    check("min_max_b2", got_q[2], 8'hFF);
`else
    fill_const(8'hFF, 8'hFF);
    build_expected();
    load_all(0);
    wait_output(1);
    receive(100, -1, 0);
    check("max_b0", got_q[0], 8'h03);
    check("max_b1", got_q[1], 8'hFA);
    check("max_b2", got_q[2], 8'h02);
`endif

    // Random data with input gaps, output back-pressure and a 5-cycle stall mid-result.
    fill_random();
    build_expected();
    load_all(30);
    wait_output(1);
    receive(70, 4, 0);

    // Abort after 10 loaded bytes, then a clean load.
    for (int e = 0; e < 10; e++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data = 8'($urandom_range(255));
    end
    @(negedge clk);
    abort = 1'b1;
    in_valid = 1'b1;
    #1;
    check("abort_load_done", done, 1'b0);
    @(negedge clk);
    abort = 1'b0;
    in_valid = 1'b0;
    #1;
    check("abort_load_state", {out_valid, busy, in_ready}, 3'b001);
    fill_random();
    build_expected();
    load_all(0);
    wait_output(1);
    receive(100, -1, 0);

    // Abort coinciding with the final output handshake.
    fill_random();
    build_expected();
    load_all(10);
    wait_output(0);
    receive(100, -1, 1);

    // Asynchronous reset in the middle of COMPUTE, then a normal transaction.
    fill_random();
    load_all(0);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;
    fill_random();
    build_expected();
    load_all(20);
    wait_output(1);
    receive(80, -1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/matmul_stream_core.md
# matmul_stream_core

Parametrised successor to the fixed 3x3 pin-level multiplier: an N x N integer matrix multiplier with a byte-serial valid/ready load port, a sequential single-MAC compute engine and a byte-serial valid/ready result port. Sits behind the Tiny Tapeout top-level wrapper; `ui_in`/`uo_out` carry data bytes, `uio` carries handshakes. Unlike its predecessor, it returns to LOAD after every result and never parks in a terminal DONE state.

## Interface
- `N`, default 3: matrix dimension, legal 2..4.
- `DW`, default 8: element width, legal 4..8; only in_data[DW-1:0] used.
- Derived: ACC_W = 2*DW + clog2(N); OB = ceil(ACC_W/8) bytes per result.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `abort`  in  1  synchronous clear; returns to LOAD next cycle.
- `in_valid`  in  1  in_data valid.
- `in_data`  in  8  element byte.
- `in_ready`  out  1  high in LOAD.
- `out_valid`  out  1  high in OUTPUT.
- `out_data`  out  8  result byte.
- `out_ready`  in  1  sink accepts out_data.
- `busy`  out  1  high in COMPUTE or OUTPUT.
- `done`  out  1  one-cycle pulse on final output byte handshake.

## Operation
- States: LOAD, COMPUTE, OUTPUT. Reset state LOAD.
- LOAD: accept on in_valid && in_ready; 2*N*N elements, A row-major then B row-major. Final accept -> COMPUTE.
- COMPUTE: one product per cycle over loops i, j, k (k innermost); acc = (k==0 ? 0 : acc) + A[i][k]*B[k][j]; at k==N-1 write C[i][j]. Exactly N^3 cycles, then OUTPUT.
- OUTPUT: C row-major, each result as OB bytes little-endian. Bits above ACC_W: zero-filled (unsigned) or sign-extended (signed). Byte advances on out_valid && out_ready. Final handshake -> LOAD, `done` pulses that cycle.
- No overflow possible: ACC_W covers N full-scale products.
- abort: priority over all handshakes; counters cleared, state LOAD, partial data discarded; C contents not cleared (irrelevant, overwritten).

## Timing
- Reset values: in_ready=1, out_valid=0, out_data=0, busy=0, done=0; all counters 0.
- in_ready is a pure state decode (no combinational path from in_valid).
- Last load accept at edge t: COMPUTE cycles t+1..t+N^3; out_valid high from edge t+N^3+1.
- out_data and out_valid stable while out_valid && !out_ready.
- Last output handshake at edge u: in_ready high after edge u; new load may be accepted on edge u+1.
- in_valid stalls freely in LOAD; out_ready stalls freely in OUTPUT; neither affects COMPUTE.
- Async reset mid-COMPUTE or mid-OUTPUT: immediate return to reset values.
- Simultaneous abort and final handshake: abort wins, `done` not pulsed.

## Configuration
- `MATMUL_SIGNED_EN` defined: A, B elements are DW-bit two's complement; signed MAC; result bytes sign-extended beyond ACC_W.
- Undefined: unsigned elements, unsigned MAC, zero-fill beyond ACC_W.

## Structure
- Package `matmul_pkg`: state enum (LOAD, COMPUTE, OUTPUT), clog2 function, ACC_W/OB derivation functions.
- Sub-module `matmul_mac`: DW x DW multiplier plus ACC_W accumulator with clear-on-k0; signedness selected by the macro.
- Top: FSM, load/index counters, A/B/C register arrays, output byte mux.

## Test plan
- N=3, DW=8, unsigned: A = identity, B = 1..9 -> nine results 1..9, bytes per result {v,00,00}; first out_valid 28 cycles after last load.
- A, B all 0xFF -> each result 195075: bytes 03,FA,02; done pulses once after 27th byte.
- `MATMUL_SIGNED_EN`: A, B all 0x80 -> 49152: bytes 00,C0,00; A all 0x80, B all 0x7F -> -48768: bytes 80,41,FF.
- Random in_valid gaps and out_ready low for 5 cycles mid-result -> out_data held constant, results unchanged vs. model.
- abort after 10 loaded bytes, then full clean load -> results match second load only, no done on abort.
- rst_n low during COMPUTE -> all outputs at reset values immediately; subsequent load/compute correct.
